// File: rtl/gpr_writeback.sv
// MEM->WB pipeline register for the general-purpose register file write port.
// It performs load byte/half extraction, misalignment detection and retirement counting.
module gpr_writeback #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  mem_valid,
  input  logic                  mem_write_enable,
  input  logic [ADDR_WIDTH-1:0] mem_write_addr,
  input  logic [DATA_WIDTH-1:0] mem_alu_result,
  input  logic                  mem_load_enable,
  input  logic [2:0]            mem_load_op,
  input  logic [DATA_WIDTH-1:0] mem_load_data,
  input  logic [1:0]            mem_byte_offset,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  load_misaligned,
  output logic [31:0]           retired_count
);

  localparam int unsigned CNT_WIDTH = 32;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;

  logic                  write_enable_q, write_enable_d;
  logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
  logic                  load_misaligned_q, load_misaligned_d;
  logic [CNT_WIDTH-1:0]  retired_count_q, retired_count_d;

  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] load_value;
  logic                  misaligned;
  logic                  reserved_op;

  // Big-endian lane selection and load extension.
  always_comb begin
    byte_sel    = mem_load_data[31:24];
    half_sel    = mem_byte_offset[1] ? mem_load_data[15:0] : mem_load_data[31:16];
    load_value  = mem_load_data;
    misaligned  = 1'b0;
    reserved_op = 1'b0;
    case (mem_byte_offset)
      2'd1:    byte_sel = mem_load_data[23:16];
      2'd2:    byte_sel = mem_load_data[15:8];
      2'd3:    byte_sel = mem_load_data[7:0];
      default: byte_sel = mem_load_data[31:24];
    endcase
    case (mem_load_op)
      OP_LB:   load_value = DATA_WIDTH'({{24{byte_sel[7]}}, byte_sel});
      OP_LBU:  load_value = DATA_WIDTH'({24'd0, byte_sel});
      OP_LH: begin
        load_value = DATA_WIDTH'({{16{half_sel[15]}}, half_sel});
        misaligned = mem_byte_offset[0];
      end
      OP_LHU: begin
        load_value = DATA_WIDTH'({16'd0, half_sel});
        misaligned = mem_byte_offset[0];
      end
      OP_LW: begin
        load_value = mem_load_data;
        misaligned = (mem_byte_offset != 2'd0);
      end
      default: reserved_op = 1'b1;
    endcase
    // Non-load instructions ignore the load op and offset entirely.
    if (!mem_load_enable) begin
      misaligned  = 1'b0;
      reserved_op = 1'b0;
    end
  end

  // Capture priority: flush bubble, then stall hold, then normal capture.
  always_comb begin
    write_enable_d    = write_enable_q;
    write_addr_d      = write_addr_q;
    write_data_d      = write_data_q;
    load_misaligned_d = load_misaligned_q;
    retired_count_d   = retired_count_q;
    if (flush) begin
      write_enable_d    = 1'b0;
      write_addr_d      = '0;
      write_data_d      = '0;
      load_misaligned_d = 1'b0;
    end else if (!stall) begin
      write_enable_d    = mem_valid & mem_write_enable & (mem_write_addr != '0)
                          & ~misaligned & ~reserved_op;
      write_addr_d      = mem_write_addr;
      write_data_d      = mem_load_enable ? load_value : mem_alu_result;
      load_misaligned_d = mem_valid & misaligned;
      if (mem_valid) begin
        retired_count_d = retired_count_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      write_enable_q    <= 1'b0;
      write_addr_q      <= '0;
      write_data_q      <= '0;
      load_misaligned_q <= 1'b0;
      retired_count_q   <= '0;
    end else begin
      write_enable_q    <= write_enable_d;
      write_addr_q      <= write_addr_d;
      write_data_q      <= write_data_d;
      load_misaligned_q <= load_misaligned_d;
      retired_count_q   <= retired_count_d;
    end
  end

  assign write_enable    = write_enable_q;
  assign write_addr      = write_addr_q;
  assign write_data      = write_data_q;
  assign load_misaligned = load_misaligned_q;
  assign retired_count   = retired_count_q;

endmodule
